tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_pkg.sv | 13 +
 rtl/demux1to4.sv | 16 +
 rtl/tdm_demux4.sv | 99 +++++++++
 tb/tb_tdm_demux4.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the four-slot TDM demultiplexer.
// State encoding and slot geometry used by the top and its decoder.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

endpackage

// File: rtl/demux1to4.sv
// One-hot slot write-enable decoder.
// A single enable is steered to one of four outputs by a 2-bit select.
module demux1to4
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0]    sel,
    input  logic                 en,
    output logic [NUM_SLOTS-1:0] y
);

    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with frame-sync lock tracking.
// Slots 0..2 land in shadows; slot 3 commits the whole frame at once.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             locked
);

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [WIDTH-1:0]    shadow0;
    logic [WIDTH-1:0]    shadow1;
    logic [WIDTH-1:0]    shadow2;
    logic [SLOT_W-1:0]   wr_sel;
    logic                wr_en;
    logic [NUM_SLOTS-1:0] slot_en;

    // A sync sample always restarts at slot 0; otherwise only a locked,
    // mid-frame sample is kept. Enable 3 doubles as the frame commit.
    always_comb begin
        wr_sel = frame_sync ? '0 : slot;
        wr_en  = din_valid &&
                 (frame_sync || (state == LOCKED && slot != '0));
    end

    demux1to4 u_demux (
        .sel (wr_sel),
        .en  (wr_en),
        .y   (slot_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= '0;
            shadow0     <= '0;
            shadow1     <= '0;
            shadow2     <= '0;
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            ch3         <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (slot_en[0]) shadow0 <= din;
            if (slot_en[1]) shadow1 <= din;
            if (slot_en[2]) shadow2 <= din;
            if (slot_en[3]) begin
                ch0         <= shadow0;
                ch1         <= shadow1;
                ch2         <= shadow2;
                ch3         <= din;
                frame_valid <= 1'b1;
            end
            if (din_valid) begin
                unique case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            slot   <= SLOT_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (frame_sync) begin
                            sync_err <= (slot != '0);
                            slot     <= SLOT_W'(1);
                        end else if (slot == '0) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else begin
                            // slot 3 wraps to 0 by overflow
                            slot <= slot + SLOT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4.
// Inputs change 1 time unit after each rising edge; outputs are read there too.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic       frame_valid;
    logic       sync_err;
    logic       locked;

    int passed = 0;
    int total  = 0;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [7:0] d, input logic v, input logic s);
        din        = d;
        din_valid  = v;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_flags(input string tag, input logic fv,
                             input logic se, input logic lk);
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(se));
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
    endtask

    task automatic chk_ch(input string tag, input logic [31:0] exp);
        chk({tag, ".ch"}, {ch0, ch1, ch2, ch3}, exp);
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        #1;
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'hFF, 1'b1, 1'b1);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk_ch("reset", 32'h00000000);
        rst = 1'b0;

        // unsynced samples from reset are dropped
        cyc(8'h01, 1'b1, 1'b0);
        chk_flags("hunt1", 1'b0, 1'b0, 1'b0);
        cyc(8'h02, 1'b1, 1'b0);
        chk_flags("hunt2", 1'b0, 1'b0, 1'b0);
        chk_ch("hunt2", 32'h00000000);

        // basic frame
        cyc(8'h11, 1'b1, 1'b1);
        chk_flags("f1.s0", 1'b0, 1'b0, 1'b1);
        cyc(8'h22, 1'b1, 1'b0);
        cyc(8'h33, 1'b1, 1'b0);
        chk_flags("f1.s2", 1'b0, 1'b0, 1'b1);
        chk_ch("f1.s2", 32'h00000000);
        cyc(8'h44, 1'b1, 1'b0);
        chk_flags("f1.s3", 1'b1, 1'b0, 1'b1);
        chk_ch("f1.s3", 32'h11223344);
        cyc(8'h99, 1'b0, 1'b1);
        chk_flags("f1.idle", 1'b0, 1'b0, 1'b1);
        chk_ch("f1.idle", 32'h11223344);

        // frame with gaps
        cyc(8'h11, 1'b1, 1'b1);
        cyc(8'h22, 1'b1, 1'b0);
        cyc(8'h77, 1'b0, 1'b0);
        chk_flags("f2.gap1", 1'b0, 1'b0, 1'b1);
        cyc(8'h77, 1'b0, 1'b1);
        chk_flags("f2.gap2", 1'b0, 1'b0, 1'b1);
        cyc(8'h33, 1'b1, 1'b0);
        chk_flags("f2.s2", 1'b0, 1'b0, 1'b1);
        cyc(8'h44, 1'b1, 1'b0);
        chk_flags("f2.s3", 1'b1, 1'b0, 1'b1);
        chk_ch("f2.s3", 32'h11223344);

        // early sync restarts the frame
        cyc(8'hAA, 1'b1, 1'b1);
        cyc(8'hBB, 1'b1, 1'b0);
        cyc(8'hCC, 1'b1, 1'b1);
        chk_flags("early.sync", 1'b0, 1'b1, 1'b1);
        chk_ch("early.sync", 32'h11223344);
        cyc(8'hDD, 1'b1, 1'b0);
        chk_flags("early.s1", 1'b0, 1'b0, 1'b1);
        cyc(8'hEE, 1'b1, 1'b0);
        chk_ch("early.s2", 32'h11223344);
        cyc(8'hFF, 1'b1, 1'b0);
        chk_flags("early.s3", 1'b1, 1'b0, 1'b1);
        chk_ch("early.s3", 32'hCCDDEEFF);

        // missing sync at slot 0 drops lock
        cyc(8'h55, 1'b1, 1'b0);
        chk_flags("miss", 1'b0, 1'b1, 1'b0);
        chk_ch("miss", 32'hCCDDEEFF);
        cyc(8'h56, 1'b1, 1'b0);
        chk_flags("miss.hunt", 1'b0, 1'b0, 1'b0);
        cyc(8'h61, 1'b1, 1'b1);
        chk_flags("relock", 1'b0, 1'b0, 1'b1);
        cyc(8'h62, 1'b1, 1'b0);
        cyc(8'h63, 1'b1, 1'b0);
        cyc(8'h64, 1'b1, 1'b0);
        chk_flags("relock.s3", 1'b1, 1'b0, 1'b1);
        chk_ch("relock.s3", 32'h61626364);

        // reset mid-frame discards the partial frame
        cyc(8'h71, 1'b1, 1'b1);
        cyc(8'h72, 1'b1, 1'b0);
        cyc(8'h73, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(8'h74, 1'b1, 1'b0);
        chk_flags("rst.mid", 1'b0, 1'b0, 1'b0);
        chk_ch("rst.mid", 32'h00000000);
        rst = 1'b0;
        cyc(8'h10, 1'b1, 1'b1);
        chk_flags("post.s0", 1'b0, 1'b0, 1'b1);
        cyc(8'h20, 1'b1, 1'b0);
        cyc(8'h30, 1'b1, 1'b0);
        chk_flags("post.s2", 1'b0, 1'b0, 1'b1);
        cyc(8'h40, 1'b1, 1'b0);
        chk_flags("post.s3", 1'b1, 1'b0, 1'b1);
        chk_ch("post.s3", 32'h10203040);
        cyc(8'h00, 1'b0, 1'b0);
        chk_flags("post.idle", 1'b0, 1'b0, 1'b1);
        chk_ch("post.idle", 32'h10203040);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
